// File: rtl/eth_rx_arbiter_if.sv
// Byte-stream bundle between the upstream RX ports, the arbiter and the
// Ethernet parser. The arbiter uses the slave view; a stream source/sink
// (e.g. the MAC side and the parser together) uses the master view.
interface eth_rx_arbiter_if #(
  parameter int N_PORTS = 2
);
  logic [N_PORTS-1:0]      in_valid;
  logic [N_PORTS-1:0][7:0] in_data;
  logic [N_PORTS-1:0]      in_eof;
  logic [N_PORTS-1:0]      in_frame_err;
  logic [N_PORTS-1:0]      in_ready;
  logic                    out_valid;
  logic [7:0]              out_data;
  logic                    out_eof;
  logic                    out_frame_err;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, in_eof, in_frame_err,
    input  in_ready,
    input  out_valid, out_data, out_eof, out_frame_err,
    output out_ready
  );

  modport slave (
    input  in_valid, in_data, in_eof, in_frame_err,
    output in_ready,
    output out_valid, out_data, out_eof, out_frame_err,
    input  out_ready
  );
endinterface

// File: rtl/eth_rx_arbiter.sv
// Round-robin frame arbiter: merges N upstream RX byte streams into one
// registered stream, one whole frame at a time. A granted port that stalls
// mid-frame for TIMEOUT_CYCLES is aborted with a 0x00/eof/err marker byte and
// the rest of its frame is drained and discarded.
module eth_rx_arbiter #(
  parameter int N_PORTS        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  eth_rx_arbiter_if.slave            bus,
  output logic [$clog2(N_PORTS)-1:0] grant_port,
  output logic                       busy,
  output logic                       timeout_evt,
  output logic [15:0]                timeout_count
);
  localparam int PW = $clog2(N_PORTS);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PORT  = PW'(N_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_r;
  logic [PW-1:0]       rr_ptr_r;
  logic [PW-1:0]       grant_r;
  logic [CW-1:0]       stall_cnt_r;
  logic                out_valid_r;
  logic [7:0]          out_data_r;
  logic                out_eof_r;
  logic                out_err_r;
  logic                busy_r;
  logic                evt_r;
  logic [15:0]         tcount_r;

  logic [N_PORTS-1:0]  in_ready_s;
  logic [PW-1:0]       pick_s;
  logic [PW-1:0]       cand_s;
  logic                found_s;
  logic                take_s;
  logic                any_req_s;
  logic                g_valid_s;
  logic [7:0]          g_data_s;
  logic                g_eof_s;
  logic                g_err_s;
  logic                g_rdy_s;
  logic                g_xfer_s;
  logic                out_free_s;
  logic                stall_hit_s;
  logic [PW-1:0]       next_rr_s;

  assign any_req_s   = |bus.in_valid;
  assign g_valid_s   = bus.in_valid[grant_r];
  assign g_data_s    = bus.in_data[grant_r];
  assign g_eof_s     = bus.in_eof[grant_r];
  assign g_err_s     = bus.in_frame_err[grant_r];
  assign out_free_s  = !out_valid_r || bus.out_ready;
  assign stall_hit_s = (stall_cnt_r == STALL_LAST);
  assign next_rr_s   = (grant_r == LAST_PORT) ? {PW{1'b0}} : (grant_r + PW'(1));
  assign g_xfer_s    = g_valid_s && g_rdy_s;

  // Round-robin search: first requesting port at or above rr_ptr, wrapping.
  always_comb begin
    pick_s  = rr_ptr_r;
    found_s = 1'b0;
    cand_s  = rr_ptr_r;
    take_s  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand_s  = PW'((int'(rr_ptr_r) + i) % N_PORTS);
      take_s  = !found_s && bus.in_valid[cand_s];
      pick_s  = take_s ? cand_s : pick_s;
      found_s = found_s || take_s;
    end
  end

  // Ready for the granted port: output-register space in FWD, always in DRAIN.
  always_comb begin
    case (state_r)
      FWD:     g_rdy_s = out_free_s;
      DRAIN:   g_rdy_s = 1'b1;
      default: g_rdy_s = 1'b0;
    endcase
  end

  // Fan the granted port's ready out to a one-hot per-port vector.
  always_comb begin
    if (g_rdy_s) begin
      in_ready_s = {{(N_PORTS-1){1'b0}}, 1'b1} << grant_r;
    end else begin
      in_ready_s = {N_PORTS{1'b0}};
    end
  end

  // Arbitration FSM with output register, stall timer and abort bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {PW{1'b0}};
      grant_r     <= {PW{1'b0}};
      stall_cnt_r <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_eof_r   <= 1'b0;
      out_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      evt_r       <= 1'b0;
      tcount_r    <= 16'h0000;
    end else begin
      evt_r <= 1'b0;
      // The parser taking the current byte frees the register unless reloaded below.
      if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r     <= pick_s;
            stall_cnt_r <= {CW{1'b0}};
            busy_r      <= 1'b1;
            state_r     <= FWD;
          end
        end
        FWD: begin
          if (g_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= g_data_s;
            out_eof_r   <= g_eof_s;
            out_err_r   <= g_err_s;
            if (g_eof_s) begin
              rr_ptr_r <= next_rr_s;
              busy_r   <= 1'b0;
              state_r  <= IDLE;
            end
          end
          // Only a silent upstream counts; output backpressure keeps in_valid high.
          if (g_valid_s) begin
            stall_cnt_r <= {CW{1'b0}};
          end else if (stall_hit_s) begin
            stall_cnt_r <= {CW{1'b0}};
            state_r     <= ABORT;
          end else begin
            stall_cnt_r <= stall_cnt_r + CW'(1);
          end
        end
        ABORT: begin
          if (out_free_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= 8'h00;
            out_eof_r   <= 1'b1;
            out_err_r   <= 1'b1;
            evt_r       <= 1'b1;
            if (tcount_r != 16'hFFFF) begin
              tcount_r <= tcount_r + 16'd1;
            end
            stall_cnt_r <= {CW{1'b0}};
            state_r     <= DRAIN;
          end
        end
        DRAIN: begin
          // Every byte is accepted and dropped here; eof or a second stall ends the frame.
          if (g_valid_s) begin
            stall_cnt_r <= {CW{1'b0}};
            if (g_eof_s) begin
              rr_ptr_r <= next_rr_s;
              busy_r   <= 1'b0;
              state_r  <= IDLE;
            end
          end else if (stall_hit_s) begin
            stall_cnt_r <= {CW{1'b0}};
            rr_ptr_r    <= next_rr_s;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            stall_cnt_r <= stall_cnt_r + CW'(1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_data      = out_data_r;
  assign bus.out_eof       = out_eof_r;
  assign bus.out_frame_err = out_err_r;
  assign grant_port        = grant_r;
  assign busy              = busy_r;
  assign timeout_evt       = evt_r;
  assign timeout_count     = tcount_r;
endmodule

// File: tb/tb_eth_rx_arbiter.sv
// Scoreboard bench for eth_rx_arbiter (2 ports, 16-cycle timeout). A driver
// feeds per-port byte queues, the plan tasks push expected output beats in the
// order round-robin frame arbitration must produce, and a monitor pops and
// compares every beat the parser accepts.
module tb_eth_rx_arbiter;
  localparam int NP = 2;
  localparam int TO = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [0:0]  grant_port;
  logic        busy;
  logic        timeout_evt;
  logic [15:0] timeout_count;

  eth_rx_arbiter_if #(.N_PORTS(NP)) bus ();

  eth_rx_arbiter #(.N_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grant_port(grant_port),
    .busy(busy), .timeout_evt(timeout_evt), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic idle; logic [7:0] d; logic eof; logic err;} drv_t;
  typedef struct packed {logic [7:0] d; logic eof; logic err; logic chk_g; logic [7:0] port;} exp_t;

  drv_t port_q[NP][$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rr_model = 0;
  int   rdy_pct = 100;
  int   rst_cycles = 3;
  bit   mid_rst = 1'b0;
  int   evt_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue len bytes on port p; optionally expect them on the output.
  task automatic add_seg(input int p, input int len, input bit with_eof, input bit err,
                         input bit expect_out, input bit first_of_frame);
    drv_t b;
    exp_t e;
    for (int i = 0; i < len; i++) begin
      b.idle = 1'b0;
      b.d    = 8'($urandom);
      b.eof  = with_eof && (i == len - 1);
      b.err  = b.eof && err;
      port_q[p].push_back(b);
      if (expect_out) begin
        e.d     = b.d;
        e.eof   = b.eof;
        e.err   = b.err;
        e.chk_g = first_of_frame && (i == 0) && !b.eof;
        e.port  = 8'(p);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic add_idle(input int p, input int n);
    drv_t b;
    b = '0;
    b.idle = 1'b1;
    for (int i = 0; i < n; i++) port_q[p].push_back(b);
  endtask

  // Both ports hold frames back to back, so frames must alternate from rr_model.
  task automatic plan_alt(input int nfr, input int minl, input int maxl, input bit rand_err);
    int p;
    p = rr_model;
    for (int f = 0; f < 2 * nfr; f++) begin
      add_seg(p, $urandom_range(minl, maxl), 1'b1, rand_err && ($urandom_range(0, 1) == 1), 1'b1, 1'b1);
      p = (p + 1) % NP;
    end
    rr_model = p;
  endtask

  task automatic wait_drain(input string name);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    while (!done && k < 3000) begin
      @(negedge clk);
      #3;
      k++;
      done = (port_q[0].size() == 0) && (port_q[1].size() == 0) && (exp_q.size() == 0) && !bus.out_valid;
    end
    check({"drain_", name}, 32'(done), 32'd1);
    if (!done) begin
      port_q[0].delete();
      port_q[1].delete();
      exp_q.delete();
    end
  endtask

  // Driver: presents queue heads each cycle and pops on handshake; owns rst_n.
  initial begin : driver
    exp_t e;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.in_eof = '0;
    bus.in_frame_err = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_cycles > 0) begin
        rst_n = 1'b0;
        rst_cycles--;
      end else begin
        rst_n = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      for (int p = 0; p < NP; p++) begin
        if (port_q[p].size() > 0 && !port_q[p][0].idle) begin
          bus.in_valid[p] = 1'b1;
          bus.in_data[p] = port_q[p][0].d;
          bus.in_eof[p] = port_q[p][0].eof;
          bus.in_frame_err[p] = port_q[p][0].err;
        end else begin
          bus.in_valid[p] = 1'b0;
          bus.in_data[p] = 8'h00;
          bus.in_eof[p] = 1'b0;
          bus.in_frame_err[p] = 1'b0;
        end
      end
      #1;
      if (mid_rst) begin
        mid_rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_flags", 32'({bus.out_eof, bus.out_frame_err}), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_port), 32'd0);
        // Partial frame is lost; what is still upstream is a fresh frame from port 0.
        exp_q.delete();
        for (int i = 0; i < port_q[0].size(); i++) begin
          e.d = port_q[0][i].d;
          e.eof = port_q[0][i].eof;
          e.err = port_q[0][i].err;
          e.chk_g = (i == 0) && !port_q[0][i].eof;
          e.port = 8'd0;
          exp_q.push_back(e);
        end
        add_seg(1, 3, 1'b1, 1'b0, 1'b1, 1'b1);
        rr_model = 0;
        evt_cnt = 0;
      end
      for (int p = 0; p < NP; p++) begin
        if (port_q[p].size() > 0) begin
          if (port_q[p][0].idle || bus.in_ready[p]) void'(port_q[p].pop_front());
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted beat and checks hold stability.
  initial begin : monitor
    exp_t e;
    bit hold;
    logic [9:0] held;
    bit prev_evt;
    hold = 1'b0;
    held = '0;
    prev_evt = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 1'b0;
        prev_evt = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_stable", 32'({bus.out_data, bus.out_eof, bus.out_frame_err}), 32'(held));
        end
        if (timeout_evt) begin
          evt_cnt++;
          check("evt_width", 32'(prev_evt), 32'd0);
        end
        prev_evt = timeout_evt;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(bus.out_data), 32'(e.d));
            check("out_eof", 32'(bus.out_eof), 32'(e.eof));
            check("out_err", 32'(bus.out_frame_err), 32'(e.err));
            if (e.chk_g) check("grant_port", 32'(grant_port), 32'(e.port));
          end
        end
        hold = bus.out_valid && !bus.out_ready;
        held = {bus.out_data, bus.out_eof, bus.out_frame_err};
      end
    end
  end

  // Main sequence of directed and randomized phases.
  initial begin : main
    int t0;
    bit seen;
    #3;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'd0);
    check("reset_out_flags", 32'({bus.out_eof, bus.out_frame_err}), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_grant", 32'(grant_port), 32'd0);
    check("reset_evt", 32'(timeout_evt), 32'd0);
    check("reset_tcount", 32'(timeout_count), 32'd0);
    repeat (6) @(negedge clk);
    #3;

    // 64-byte frame on port 0 with latency measurement.
    rdy_pct = 100;
    add_seg(0, 64, 1'b1, 1'b0, 1'b1, 1'b1);
    rr_model = 1;
    @(negedge clk);
    t0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      #3;
      seen = bus.out_valid;
    end
    check("first_out_latency", 32'(cyc - t0), 32'd2);
    wait_drain("single64");

    // Both ports streaming 3-byte frames: strict alternation.
    plan_alt(4, 3, 3, 1'b0);
    wait_drain("alt3");

    // Random lengths and errors under 50% backpressure.
    rdy_pct = 50;
    plan_alt(5, 1, 6, 1'b1);
    wait_drain("alt_rand");

    // 100-byte frame under random backpressure.
    add_seg(0, 100, 1'b1, 1'b0, 1'b1, 1'b1);
    rr_model = 1;
    wait_drain("bp100");

    // Port 1 stalls mid-frame: abort marker, drain, then port 0.
    rdy_pct = 100;
    evt_cnt = 0;
    add_seg(1, 5, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back('{d: 8'h00, eof: 1'b1, err: 1'b1, chk_g: 1'b0, port: 8'd1});
    add_idle(1, 20);
    add_seg(1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    add_idle(0, 12);
    add_seg(0, 4, 1'b1, 1'b0, 1'b1, 1'b1);
    rr_model = 1;
    wait_drain("timeout");
    check("timeout_evt_count", 32'(evt_cnt), 32'd1);
    check("timeout_count", 32'(timeout_count), 32'd1);

    // Single-byte error frame, FSM back in IDLE on the following cycle.
    add_seg(0, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #3;
      seen = bus.in_valid[0] && bus.in_ready[0];
    end
    @(negedge clk);
    #3;
    check("busy_after_1byte", 32'(busy), 32'd0);
    wait_drain("err1");

    // Reset pulse in the middle of a port-0 frame.
    add_seg(0, 30, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    #3;
    rst_cycles = 1;
    mid_rst = 1'b1;
    wait_drain("mid_reset");
    check("tcount_after_reset", 32'(timeout_count), 32'd0);
    check("evt_after_reset", 32'(evt_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/eth_rx_arbiter.md
ETH_RX_ARBITER -- requirements
Module: eth_rx_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2: number of upstream RX byte-stream ports (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: idle-stall cycles before a granted frame is aborted (>=2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  N_PORTS  per-port byte valid.
REQ-006 in_data  input  N_PORTS x byte_t  per-port byte.
REQ-007 in_eof  input  N_PORTS  per-port last byte of frame.
REQ-008 in_frame_err  input  N_PORTS  per-port MAC/CRC error, qualified with in_eof.
REQ-009 in_ready  output  N_PORTS  per-port accept; byte transfers when in_valid and in_ready both high.
REQ-010 out_valid, out_data (byte_t), out_eof, out_frame_err  output  1/8/1/1  registered stream to the Ethernet parser.
REQ-011 out_ready  input  1  parser accept.
REQ-012 grant_port  output  $clog2(N_PORTS)  currently/last granted port.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 timeout_evt  output  1  one-cycle pulse on each abort.
REQ-015 timeout_count  output  16  saturating count of aborts.

Function
REQ-016 FSM states SHALL be IDLE, FWD, ABORT, DRAIN; exactly one port granted outside IDLE.
REQ-017 IDLE: all in_ready low; if any in_valid high, grant first valid port searching upward from rr_ptr with wrap, enter FWD next cycle.
REQ-018 rr_ptr SHALL become (granted port + 1) mod N_PORTS when that grant releases; simultaneous requests never starve.
REQ-019 Only the granted port SHALL see in_ready high; in_ready[g] = !out_valid || out_ready in FWD, constant 1 in DRAIN.
REQ-020 Output register SHALL hold data/eof/frame_err stable while out_valid && !out_ready.
REQ-021 FWD: each accepted byte loads output register with data, eof, frame_err unchanged; out_valid high next cycle.
REQ-022 Latency: in_valid rising in IDLE at cycle t -> first byte accepted t+1 -> out_valid t+2.
REQ-023 FWD: accepted byte with in_eof SHALL return to IDLE; single-byte frames legal; one-cycle IDLE bubble between frames.
REQ-024 Stall counter SHALL clear on grant and whenever in_valid[g] is high; increment in FWD/DRAIN while in_valid[g] is low; output backpressure never counts.
REQ-025 Stall counter reaching TIMEOUT_CYCLES in FWD SHALL enter ABORT.
REQ-026 ABORT: when output register free, load out_data 0x00, out_eof 1, out_frame_err 1; pulse timeout_evt; increment timeout_count (saturate 0xFFFF); enter DRAIN.
REQ-027 DRAIN: discard granted port bytes, forward nothing; accepted eof or second stall timeout -> IDLE with rr_ptr advance.
REQ-028 Stall timeout in DRAIN SHALL NOT pulse timeout_evt or increment timeout_count.
REQ-029 Error frames (in_frame_err with in_eof) in FWD SHALL pass through unmodified; arbiter never drops them.

Reset
REQ-030 On rst_n low: state IDLE, rr_ptr 0, stall counter 0, out_valid/out_data/out_eof/out_frame_err 0, in_ready 0, grant_port 0, busy 0, timeout_evt 0, timeout_count 0.
REQ-031 Reset mid-frame SHALL discard the partial frame with no eof emitted; next upstream byte is treated as a new request.

Verification (N_PORTS=2, TIMEOUT_CYCLES=16)
REQ-032 Port0 sends 64-byte frame, out_ready=1 -> 64 bytes out in order, eof on byte 64, first out_valid 2 cycles after in_valid.
REQ-033 Both ports valid continuously, 3-byte frames each -> output alternates P0,P1,P0,P1 by frame; grant_port toggles; no interleaved bytes.
REQ-034 Random out_ready 50% on 100-byte frame -> byte sequence identical, output held stable under stall, no loss or duplication.
REQ-035 Port1 sends 5 bytes then idles 16 cycles -> 0x00 with eof=1, frame_err=1 emitted; timeout_evt 1 cycle; timeout_count=1; remaining bytes until port1 eof discarded; port0 then granted.
REQ-036 Port0 sends 1-byte frame with in_eof=1, in_frame_err=1 -> one byte out with out_eof=1, out_frame_err=1, state IDLE next cycle.
REQ-037 rst_n low for 1 cycle mid-frame on port0 -> all outputs 0 immediately, busy 0, then normal arbitration after release.
